// File: rtl/shifter_8_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_8_seq_if
//  Description : Handshake and data bundle for the iterative shift/rotate
//                unit. The requester drives start/op/amount/operand. The
//                shifter returns the result, status flags and the
//                busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shifter_8_seq_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] from_shifter;
   logic             busy;
   logic             done;
   logic             carry_out;
   logic             zero;

   // Requester side: issues operations and consumes results
   modport master (
      output start,
      output op,
      output amount,
      output operand,
      input  from_shifter,
      input  busy,
      input  done,
      input  carry_out,
      input  zero
   );

   // Shifter side: accepts operations and produces results
   modport slave (
      input  start,
      input  op,
      input  amount,
      input  operand,
      output from_shifter,
      output busy,
      output done,
      output carry_out,
      output zero
   );
endinterface
`default_nettype wire

// File: rtl/shifter_8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_8_seq
//  Description : Iterative shift/rotate unit. It performs one single-bit
//                SLL/SRL/SRA/ROL/ROR step per clock under a start/busy/done
//                handshake. The working register drives from_shifter
//                directly. carry_out and zero are registered with each update.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_8_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   shifter_8_seq_if.slave bus
);

   // Operation encodings. Codes above c_OP_ROR are pass-through.
   localparam logic [2:0] c_OP_SLL = 3'd0;
   localparam logic [2:0] c_OP_SRL = 3'd1;
   localparam logic [2:0] c_OP_SRA = 3'd2;
   localparam logic [2:0] c_OP_ROL = 3'd3;
   localparam logic [2:0] c_OP_ROR = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] w_nextWork;
   logic [AMT_W-1:0] r_count;
   logic [AMT_W-1:0] w_nextCount;
   logic [2:0]       r_op;
   logic [2:0]       w_nextOp;
   logic             r_carry;
   logic             w_nextCarry;
   logic             r_zero;
   logic             w_nextZero;
   logic             w_immediate;
   logic [WIDTH:0]   w_step;

   // One single-bit step of the selected operation.
   // The return value is {bit shifted out, new word}.
   function automatic logic [WIDTH:0] f_stepOnce(
      input logic [2:0]       opSel,
      input logic [WIDTH-1:0] val
   );
      logic [WIDTH:0] res;
      res = {1'b0, val};
      case (opSel)
         c_OP_SLL: res = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
         c_OP_SRL: res = {val[0], 1'b0, val[WIDTH-1:1]};
         c_OP_SRA: res = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
         c_OP_ROL: res = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
         c_OP_ROR: res = {val[0], val[0], val[WIDTH-1:1]};
         default:  res = {1'b0, val};
      endcase
      return res;
   endfunction

   // A zero amount or a pass-through opcode finishes without shifting
   assign w_immediate = (bus.amount == '0) || (bus.op > c_OP_ROR);

   // Result of stepping the current working word once with the latched op
   always_comb begin
      w_step = f_stepOnce(r_op, r_work);
   end

   // Next-state and datapath update: load on an accepted start, step while shifting
   always_comb begin
      w_nextState = r_state;
      w_nextWork  = r_work;
      w_nextCount = r_count;
      w_nextOp    = r_op;
      w_nextCarry = r_carry;
      w_nextZero  = r_zero;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            // DONE always leaves after one cycle.
            // A start seen here is accepted back-to-back, as from IDLE.
            w_nextState = ST_IDLE;
            if (bus.start) begin
               w_nextWork  = bus.operand;
               w_nextCount = bus.amount;
               w_nextOp    = bus.op;
               w_nextCarry = 1'b0;
               w_nextZero  = (bus.operand == '0);
               w_nextState = w_immediate ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // start, op, amount and operand are ignored here
            w_nextWork  = w_step[WIDTH-1:0];
            w_nextCarry = w_step[WIDTH];
            w_nextZero  = (w_step[WIDTH-1:0] == '0);
            w_nextCount = r_count - AMT_W'(1);
            // Exiting on count == 1 means count never wraps below zero
            if (r_count == AMT_W'(1)) begin
               w_nextState = ST_DONE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers. A synchronous active-low reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_work  <= '0;
         r_count <= '0;
         r_op    <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_work  <= w_nextWork;
         r_count <= w_nextCount;
         r_op    <= w_nextOp;
         r_carry <= w_nextCarry;
         r_zero  <= w_nextZero;
      end
   end

   // The outputs come straight from registers, so the mux input never glitches
   assign bus.from_shifter = r_work;
   assign bus.carry_out    = r_carry;
   assign bus.zero         = r_zero;
   assign bus.busy         = (r_state == ST_SHIFT);
   assign bus.done         = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shifter_8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_8_seq
//  Description : Directed, table-driven self-checking bench for shifter_8_seq
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_8_seq;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   shifter_8_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

   shifter_8_seq #(.WIDTH(8), .AMT_W(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [2:0] amount;
      logic [7:0] operand;
      logic [7:0] expResult;
      logic       expCarry;
      logic       expZero;
      int         latency;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issue one operation from idle.
   // Check the busy window, the done latency, the result and flags, and that done lasts one cycle.
   task automatic runVector(input vec_t v, input int idx);
      int  cycles;
      logic busyGap;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = v.op;
      bus.amount  = v.amount;
      bus.operand = v.operand;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.operand = 8'hA5;
      cycles  = 0;
      busyGap = 1'b0;
      while (!bus.done && cycles < 40) begin
         if (!bus.busy) busyGap = 1'b1;
         @(negedge clk);
         cycles++;
      end
      chk($sformatf("v%0d_latency", idx), cycles, v.latency);
      chk($sformatf("v%0d_busyHeld", idx), {31'd0, busyGap}, 32'd0);
      chk($sformatf("v%0d_result", idx), {24'd0, bus.from_shifter}, {24'd0, v.expResult});
      chk($sformatf("v%0d_carry", idx), {31'd0, bus.carry_out}, {31'd0, v.expCarry});
      chk($sformatf("v%0d_zero", idx), {31'd0, bus.zero}, {31'd0, v.expZero});
      chk($sformatf("v%0d_busyAtDone", idx), {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_donePulse", idx), {31'd0, bus.done}, 32'd0);
      chk($sformatf("v%0d_resultHeld", idx), {24'd0, bus.from_shifter}, {24'd0, v.expResult});
   endtask

   initial begin
      int   cycles;
      logic sawDone;
      checks = 0;
      errors = 0;

      vecs[0]  = '{3'd0, 3'd3, 8'hB1, 8'h88, 1'b1, 1'b0, 3};
      vecs[1]  = '{3'd2, 3'd2, 8'h90, 8'hE4, 1'b0, 1'b0, 2};
      vecs[2]  = '{3'd4, 3'd1, 8'h01, 8'h80, 1'b1, 1'b0, 1};
      vecs[3]  = '{3'd1, 3'd1, 8'h01, 8'h00, 1'b1, 1'b1, 1};
      vecs[4]  = '{3'd0, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 0};
      vecs[5]  = '{3'd6, 3'd5, 8'h5A, 8'h5A, 1'b0, 1'b0, 0};
      vecs[6]  = '{3'd3, 3'd4, 8'h81, 8'h18, 1'b0, 1'b0, 4};
      vecs[7]  = '{3'd1, 3'd7, 8'h80, 8'h01, 1'b0, 1'b0, 7};
      vecs[8]  = '{3'd2, 3'd7, 8'h80, 8'hFF, 1'b0, 1'b0, 7};
      vecs[9]  = '{3'd3, 3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 1};
      vecs[10] = '{3'd0, 3'd1, 8'h80, 8'h00, 1'b1, 1'b1, 1};
      vecs[11] = '{3'd7, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 0};

      // Reset held for two edges while start is asserted
      reset_n     = 1'b0;
      bus.start   = 1'b1;
      bus.op      = 3'd0;
      bus.amount  = 3'd3;
      bus.operand = 8'hFF;
      @(negedge clk);
      chk("rst_done1", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      chk("rst_done2", {31'd0, bus.done}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_result", {24'd0, bus.from_shifter}, 32'd0);
      chk("rst_carry", {31'd0, bus.carry_out}, 32'd0);
      chk("rst_zero", {31'd0, bus.zero}, 32'd0);
      bus.start = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         runVector(vecs[i], i);
      end

      // Back-to-back: ROR 01 by 1, then SRL 01 by 1 started during the done cycle
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.amount = 3'd1; bus.operand = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy1", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      chk("b2b_done1", {31'd0, bus.done}, 32'd1);
      chk("b2b_result1", {24'd0, bus.from_shifter}, 32'h80);
      chk("b2b_carry1", {31'd0, bus.carry_out}, 32'd1);
      bus.start = 1'b1; bus.op = 3'd1; bus.amount = 3'd1; bus.operand = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy2", {31'd0, bus.busy}, 32'd1);
      chk("b2b_done2off", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      chk("b2b_done2", {31'd0, bus.done}, 32'd1);
      chk("b2b_result2", {24'd0, bus.from_shifter}, 32'h00);
      chk("b2b_carry2", {31'd0, bus.carry_out}, 32'd1);
      chk("b2b_zero2", {31'd0, bus.zero}, 32'd1);
      @(negedge clk);

      // Ignore: a start pulse mid-shift must not disturb ROL 81 by 4
      bus.start = 1'b1; bus.op = 3'd3; bus.amount = 3'd4; bus.operand = 8'h81;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.amount = 3'd1; bus.operand = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      cycles = 2;
      while (!bus.done && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      chk("ign_latency", cycles, 4);
      chk("ign_result", {24'd0, bus.from_shifter}, 32'h18);
      chk("ign_carry", {31'd0, bus.carry_out}, 32'd0);
      @(negedge clk);

      // Abort: reset dropped after two shift steps
      bus.start = 1'b1; bus.op = 3'd3; bus.amount = 3'd4; bus.operand = 8'h81;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abt_midBusy", {31'd0, bus.busy}, 32'd1);
      chk("abt_midResult", {24'd0, bus.from_shifter}, 32'h06);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abt_result", {24'd0, bus.from_shifter}, 32'd0);
      chk("abt_busy", {31'd0, bus.busy}, 32'd0);
      chk("abt_carry", {31'd0, bus.carry_out}, 32'd0);
      chk("abt_zero", {31'd0, bus.zero}, 32'd0);
      sawDone = bus.done;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (bus.done) sawDone = 1'b1;
         @(negedge clk);
      end
      chk("abt_noDone", {31'd0, sawDone}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
